spi_reg_bridge: RTL

- SPI slave (mode 0) giving the external MCU access to the 8-byte register map used by the tone-detect controller.
- Sits directly upstream of the controller: drives its MCU-status and sample-in byte inputs, and returns its ASIC-status and result bytes to the MCU.
- All SPI pins are oversampled in the system clock domain; there is no SCLK clock domain.

---
 rtl/spi_reg_pkg.sv | 38 +++
 rtl/spi_reg_bridge_if.sv | 13 +
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_reg_bridge.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// Shared constants and types for the SPI register bridge: address map,
// frame FSM encoding and mcu_status_lsb bit positions.
package spi_reg_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 7;

  localparam logic [ADDR_W-1:0] ADDR_MCU_STAT_L  = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_MCU_STAT_M  = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_SAMPLE_L    = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_SAMPLE_M    = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_ASIC_STAT_L = 7'h04;
  localparam logic [ADDR_W-1:0] ADDR_ASIC_STAT_M = 7'h05;
  localparam logic [ADDR_W-1:0] ADDR_RESULTS_L   = 7'h06;
  localparam logic [ADDR_W-1:0] ADDR_RESULTS_M   = 7'h07;

  localparam int unsigned MCU_BIT_SAMPLE_VALID = 0;
  localparam int unsigned MCU_BIT_ACK_DONE     = 1;
  localparam int unsigned MCU_BIT_START        = 2;
  localparam int unsigned MCU_BIT_STREAM       = 3;
  localparam int unsigned MCU_BIT_ABORT        = 4;

  // Writing this bit of 0x01 as 1 also clears the sticky frame error
  localparam int unsigned FERR_CLR_BIT = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } spi_state_e;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
  } spi_cmd_t;

endpackage

// File: rtl/spi_reg_bridge_if.sv
// SPI pin bundle between the MCU (master) and the register bridge (slave).
interface spi_reg_bridge_if;
  logic spi_sclk;
  logic spi_cs_n;
  logic spi_mosi;
  logic spi_miso;
  logic spi_miso_oe;

  modport master (output spi_sclk, output spi_cs_n, output spi_mosi,
                  input  spi_miso, input  spi_miso_oe);
  modport slave  (input  spi_sclk, input  spi_cs_n, input  spi_mosi,
                  output spi_miso, output spi_miso_oe);
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin with rise/fall detection
// on the synchronized value.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out,
  output logic rise_c,
  output logic fall_c
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic                   prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q  <= RESET_VAL;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], async_in};
      prev_q  <= chain_q[SYNC_STAGES-1];
    end
  end

  assign sync_out = chain_q[SYNC_STAGES-1];
  assign rise_c   = sync_out & ~prev_q;
  assign fall_c   = ~sync_out & prev_q;

endmodule

// File: rtl/spi_reg_bridge.sv
// Mode-0 SPI slave exposing the tone-detect controller's 8-byte register map.
// Optional build macro SPI_SAMPLE_STROBE_EN: write of 0x03 pulses mcu_status_lsb[0].
module spi_reg_bridge
  import spi_reg_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FRAME_BITS  = 16
) (
  input  logic              clk,
  input  logic              reset,
  spi_reg_bridge_if.slave   spi,
  output logic [DATA_W-1:0] mcu_status_lsb,
  output logic [DATA_W-1:0] mcu_status_msb,
  output logic [DATA_W-1:0] sample_in_lsb,
  output logic [DATA_W-1:0] sample_in_msb,
  input  logic [DATA_W-1:0] asic_status_lsb,
  input  logic [DATA_W-1:0] asic_status_msb,
  input  logic [DATA_W-1:0] results_lsb,
  input  logic [DATA_W-1:0] results_msb,
  output logic              frame_err
);

  localparam int unsigned CNT_W    = $clog2(FRAME_BITS);
  localparam int unsigned HALF     = FRAME_BITS / 2;
  localparam int unsigned SETTLE_W = $clog2(SYNC_STAGES + 1);

  logic sclk_rise, sclk_fall, sclk_sync_unused;
  logic cs_sync, cs_fall, cs_rise_unused;
  logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk (
    .clk(clk), .reset(reset), .async_in(spi.spi_sclk),
    .sync_out(sclk_sync_unused), .rise_c(sclk_rise), .fall_c(sclk_fall));

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs (
    .clk(clk), .reset(reset), .async_in(spi.spi_cs_n),
    .sync_out(cs_sync), .rise_c(cs_rise_unused), .fall_c(cs_fall));

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi (
    .clk(clk), .reset(reset), .async_in(spi.spi_mosi),
    .sync_out(mosi_sync), .rise_c(mosi_rise_unused), .fall_c(mosi_fall_unused));

  // After reset, only accept a new frame once cs_n has been seen high
  // through a flushed synchronizer, so a frame cut by reset is ignored.
  logic [SETTLE_W-1:0] settle_q;
  logic                armed_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      settle_q <= '0;
      armed_q  <= 1'b0;
    end else begin
      if (settle_q != SETTLE_W'(SYNC_STAGES)) settle_q <= settle_q + SETTLE_W'(1);
      if (settle_q == SETTLE_W'(SYNC_STAGES) && cs_sync) armed_q <= 1'b1;
    end
  end

  spi_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             shift_en, cmd_latch, wr_commit, miso_shift, abort;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_en   = 1'b0;
    cmd_latch  = 1'b0;
    wr_commit  = 1'b0;
    miso_shift = 1'b0;
    abort      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (armed_q && cs_fall) begin
          state_d = CMD;
          cnt_d   = '0;
        end
      end
      CMD: begin
        if (cs_sync) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (sclk_rise) begin
          shift_en = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(HALF - 1)) begin
            cmd_latch = 1'b1;
            state_d   = DATA;
          end
        end
      end
      DATA: begin
        if (cs_sync) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else begin
          miso_shift = sclk_fall;
          if (sclk_rise) begin
            shift_en = 1'b1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
              wr_commit = 1'b1;
              state_d   = DONE;
            end
          end
        end
      end
      DONE: begin
        if (cs_sync) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  logic [DATA_W-2:0] shift_q;
  logic [DATA_W-1:0] rx_byte, shout_q, rd_data;
  spi_cmd_t          cmd_q, rx_cmd;
  logic              miso_q, wr_en;

  assign rx_byte = {shift_q, mosi_sync};
  assign rx_cmd  = spi_cmd_t'(rx_byte);
  assign wr_en   = wr_commit & cmd_q.rw;

  // Read source for the address arriving with the 8th rise
  always_comb begin
    rd_data = '0;
    case (rx_cmd.addr)
      ADDR_MCU_STAT_L:  rd_data = mcu_status_lsb;
      ADDR_MCU_STAT_M:  rd_data = mcu_status_msb;
      ADDR_SAMPLE_L:    rd_data = sample_in_lsb;
      ADDR_SAMPLE_M:    rd_data = sample_in_msb;
      ADDR_ASIC_STAT_L: rd_data = asic_status_lsb;
      ADDR_ASIC_STAT_M: rd_data = asic_status_msb;
      ADDR_RESULTS_L:   rd_data = results_lsb;
      ADDR_RESULTS_M:   rd_data = results_msb;
      default:          rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q        <= '0;
      cmd_q          <= '0;
      shout_q        <= '0;
      miso_q         <= 1'b0;
      frame_err      <= 1'b0;
      mcu_status_lsb <= '0;
      mcu_status_msb <= '0;
      sample_in_lsb  <= '0;
      sample_in_msb  <= '0;
    end else begin
      if (shift_en) shift_q <= rx_byte[DATA_W-2:0];
      if (cmd_latch) begin
        cmd_q   <= rx_cmd;
        shout_q <= rx_cmd.rw ? '0 : rd_data;
      end else if (miso_shift) begin
        miso_q  <= shout_q[DATA_W-1];
        shout_q <= {shout_q[DATA_W-2:0], 1'b0};
      end
      if (state_q == IDLE) miso_q <= 1'b0;
      if (abort) frame_err <= 1'b1;
`ifdef SPI_SAMPLE_STROBE_EN
      mcu_status_lsb[MCU_BIT_SAMPLE_VALID] <= wr_en && (cmd_q.addr == ADDR_SAMPLE_M);
`endif
      if (wr_en) begin
        case (cmd_q.addr)
`ifdef SPI_SAMPLE_STROBE_EN
          ADDR_MCU_STAT_L: mcu_status_lsb[DATA_W-1:1] <= rx_byte[DATA_W-1:1];
`else
          ADDR_MCU_STAT_L: mcu_status_lsb <= rx_byte;
`endif
          ADDR_MCU_STAT_M: begin
            mcu_status_msb <= rx_byte;
            if (rx_byte[FERR_CLR_BIT]) frame_err <= 1'b0;
          end
          ADDR_SAMPLE_L:   sample_in_lsb <= rx_byte;
          ADDR_SAMPLE_M:   sample_in_msb <= rx_byte;
          default: ;
        endcase
      end
    end
  end

  assign spi.spi_miso    = miso_q;
  assign spi.spi_miso_oe = ~cs_sync;

endmodule
